// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/ack memory port between the fetch (IF) and
// load/store (MEM) stages. MEM has fixed priority over IF. The bus outputs are
// registered and stay constant until bus_ack. When one side completes, its
// valid output pulses for one cycle with the read data.
// Optional build macro ARB_FETCH_BUF_EN adds a one-entry fetch buffer. A
// repeated fetch of the same word is then served without a bus transaction.
module mem_port_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         if_req,
    input  logic [W-1:0] if_addr,
    output logic [W-1:0] if_rdata,
    output logic         if_valid,
    input  logic         mem_req,
    input  logic         mem_we,
    input  logic [W-1:0] mem_addr,
    input  logic [W-1:0] mem_wdata,
    input  logic [3:0]   mem_be,
    output logic [W-1:0] mem_rdata,
    output logic         mem_valid,
    output logic         bus_req,
    output logic         bus_we,
    output logic [W-1:0] bus_addr,
    output logic [W-1:0] bus_wdata,
    output logic [3:0]   bus_be,
    input  logic [W-1:0] bus_rdata,
    input  logic         bus_ack,
    output logic         stall
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

    state_t state, state_nxt;
    logic   if_elig, mem_elig;
    logic   grant_if, grant_mem, ack_if, ack_mem;
    logic   buf_hit, buf_fetch;

    // A requester on its valid-pulse cycle still has req high; it must not re-issue
    assign if_elig  = if_req & ~if_valid;
    assign mem_elig = mem_req & ~mem_valid;
    assign stall    = if_elig | mem_elig;

`ifdef ARB_FETCH_BUF_EN
    logic           buf_vld;
    logic [W-1:2]   buf_tag;
    logic [W-1:0]   buf_data;

    assign buf_hit = buf_vld && (if_addr[W-1:2] == buf_tag);

    // Fill on every bus fetch; a store that hits the cached word invalidates it
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld  <= 1'b0;
            buf_tag  <= '0;
            buf_data <= '0;
        end else if (ack_if) begin
            buf_vld  <= 1'b1;
            buf_tag  <= bus_addr[W-1:2];
            buf_data <= bus_rdata;
        end else if (grant_mem && mem_we && (mem_addr[W-1:2] == buf_tag)) begin
            buf_vld  <= 1'b0;
        end
    end
`else
    logic [W-1:0] buf_data;
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and the grant/ack strobes that drive the datapath
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        ack_if    = 1'b0;
        ack_mem   = 1'b0;
        buf_fetch = 1'b0;
        case (state)
            IDLE: begin
                if (mem_elig) begin
                    grant_mem = 1'b1;
                    state_nxt = BUSY_MEM;
                end else if (if_elig && buf_hit) begin
                    buf_fetch = 1'b1;
                end else if (if_elig) begin
                    grant_if  = 1'b1;
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (bus_ack) begin
                    ack_if    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BUSY_MEM: begin
                if (bus_ack) begin
                    ack_mem   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered bus outputs, returned data and one-cycle valid pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= 4'b0000;
            if_rdata  <= '0;
            if_valid  <= 1'b0;
            mem_rdata <= '0;
            mem_valid <= 1'b0;
        end else begin
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            if (grant_mem) begin
                bus_req   <= 1'b1;
                bus_we    <= mem_we;
                bus_addr  <= mem_addr;
                bus_wdata <= mem_wdata;
                bus_be    <= mem_be;
            end
            if (grant_if) begin
                bus_req   <= 1'b1;
                bus_we    <= 1'b0;
                bus_addr  <= if_addr;
                bus_wdata <= '0;
                bus_be    <= 4'b1111;
            end
            if (ack_if) begin
                bus_req  <= 1'b0;
                if_rdata <= bus_rdata;
                if_valid <= 1'b1;
            end
            if (ack_mem) begin
                bus_req   <= 1'b0;
                mem_rdata <= bus_rdata;
                mem_valid <= 1'b1;
            end
            if (buf_fetch) begin
                if_rdata <= buf_data;
                if_valid <= 1'b1;
            end
        end
    end

endmodule
